// File: rtl/vid_pkg.sv
// Shared definitions for the video timing counter: default sizes, the
// per-edge counter action, and the packed compare-channel slice helper.
package vid_pkg;

  localparam int VID_CNT_W_DEFAULT = 11;
  localparam int VID_NCMP_DEFAULT  = 4;

  // Fan-in of one first-level NAND group in the decode tree.
  localparam int VID_AND_GROUP = 6;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_TICK,
    CNT_CLR
  } cnt_act_e;

  // Low bit of channel ch inside a packed bus of w-bit channels.
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/vid_and_tree.sv
// Parametrised N-input AND: 6-input NAND groups combined by a NOR stage.
// Generalises the fixed 12-input counter decode.
module vid_and_tree
  import vid_pkg::*;
#(
  parameter int N = 12
) (
  input  logic [N-1:0] bits,
  output logic         all_set
);

  localparam int NG = (N + VID_AND_GROUP - 1) / VID_AND_GROUP;
  localparam int NP = NG * VID_AND_GROUP;

  logic [NP-1:0] padded;
  logic [NG-1:0] grp_n;

  // Unused inputs of the last group are tied high so they never block the AND.
  always_comb begin
    padded         = '1;
    padded[N-1:0]  = bits;
  end

  for (genvar g = 0; g < NG; g++) begin : g_nand
    assign grp_n[g] = ~&padded[g*VID_AND_GROUP +: VID_AND_GROUP];
  end

  assign all_set = ~|grp_n;

endmodule

// File: rtl/vid_match_cnt.sv
// Video timing counter with NCMP equality match channels and wrap pulse.
// Define VID_MATCH_STICKY_EN to build the sticky status/ack/irq logic.
module vid_match_cnt
  import vid_pkg::*;
#(
  parameter int WIDTH = VID_CNT_W_DEFAULT,
  parameter int NCMP  = VID_NCMP_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetl,
  input  logic                  en,
  input  logic                  clr,
  input  logic [WIDTH-1:0]      period,
  input  logic [NCMP*WIDTH-1:0] cmp_val,
  input  logic [NCMP-1:0]       cmp_en,
  input  logic [NCMP-1:0]       ack,
  output logic [WIDTH-1:0]      count,
  output logic [NCMP-1:0]       match,
  output logic                  wrap,
  output logic [NCMP-1:0]       status,
  output logic                  irq
);

  cnt_act_e         act;
  logic [NCMP-1:0]  hit;
  logic             at_period;
  logic [WIDTH-1:0] count_d;
  logic [NCMP-1:0]  match_d;
  logic             wrap_d;

  // Equality decode is against the count currently presented (pre-increment).
  for (genvar i = 0; i < NCMP; i++) begin : g_cmp
    localparam int LO = slice_lo(i, WIDTH);
    vid_and_tree #(.N(WIDTH)) u_eq (
      .bits    (~(count ^ cmp_val[LO +: WIDTH])),
      .all_set (hit[i])
    );
  end

  vid_and_tree #(.N(WIDTH)) u_tc (
    .bits    (~(count ^ period)),
    .all_set (at_period)
  );

  assign act = clr ? CNT_CLR : (en ? CNT_TICK : CNT_HOLD);

  // NOTE: every output of a combinational block gets a default before the
  // case so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    count_d = count;
    match_d = '0;
    wrap_d  = 1'b0;
    unique case (act)
      CNT_CLR:  count_d = '0;
      CNT_TICK: begin
        // A count above period (after period was lowered) rolls over
        // naturally at 2^WIDTH with no wrap pulse.
        count_d = at_period ? '0 : count + WIDTH'(1);
        wrap_d  = at_period;
        match_d = hit & cmp_en;
      end
      default: ;
    endcase
  end

  // NOTE: flops use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      count <= '0;
      match <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_d;
      match <= match_d;
      wrap  <= wrap_d;
    end
  end

`ifdef VID_MATCH_STICKY_EN
  // A new match on the same edge as its ack keeps the flag set.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      status <= '0;
    end else begin
      status <= (status & ~ack) | match_d;
    end
  end

  assign irq = |status;
`else
  logic unused_ack;

  assign unused_ack = ^ack;
  assign status     = '0;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_vid_match_cnt.sv
// Randomised and directed bench for vid_match_cnt against a cycle-level
// reference model built from the counting and match rules.
module tb_vid_match_cnt;
  import vid_pkg::*;

  localparam int W = VID_CNT_W_DEFAULT;
  localparam int N = VID_NCMP_DEFAULT;
`ifdef VID_MATCH_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           resetl;
  logic           en, clr;
  logic [W-1:0]   period;
  logic [N*W-1:0] cmp_val;
  logic [N-1:0]   cmp_en, ack;
  logic [W-1:0]   count;
  logic [N-1:0]   match, status;
  logic           wrap, irq;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int           m_count;
  logic [N-1:0] m_match, m_status;
  logic         m_wrap;

  vid_match_cnt #(.WIDTH(W), .NCMP(N)) dut (
    .clk     (clk),
    .resetl  (resetl),
    .en      (en),
    .clr     (clr),
    .period  (period),
    .cmp_val (cmp_val),
    .cmp_en  (cmp_en),
    .ack     (ack),
    .count   (count),
    .match   (match),
    .wrap    (wrap),
    .status  (status),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_cmp(input int ch, input int v);
    cmp_val[ch*W +: W] = W'(v);
  endtask

  function automatic int cmp_of(input int ch);
    return int'(cmp_val[ch*W +: W]);
  endfunction

  // One clock: predict from the current inputs, clock, then compare.
  task automatic cycle();
    int nc;
    logic [N-1:0] mm;
    logic mw;
    mm = '0;
    mw = 1'b0;
    nc = m_count;
    if (clr) begin
      nc = 0;
    end else if (en) begin
      mw = (m_count == int'(period));
      for (int i = 0; i < N; i++)
        mm[i] = cmp_en[i] && (m_count == cmp_of(i));
      nc = mw ? 0 : (m_count + 1) % (1 << W);
    end
    m_count  = nc;
    m_match  = mm;
    m_wrap   = mw;
    m_status = STICKY ? ((m_status & ~ack) | mm) : '0;
    @(posedge clk);
    #1;
    check("count",  32'(count),  32'(m_count));
    check("match",  32'(match),  32'(m_match));
    check("wrap",   32'(wrap),   32'(m_wrap));
    check("status", 32'(status), 32'(m_status));
    check("irq",    32'(irq),    32'(|m_status));
  endtask

  initial begin
    int wraps;
    resetl  = 1'b0;
    en      = 1'b1;
    clr     = 1'b0;
    period  = W'(5);
    cmp_val = '0;
    cmp_en  = '0;
    ack     = '0;

    // Reset held with en active.
    repeat (3) @(posedge clk);
    #1;
    check("rst_count",  32'(count),  0);
    check("rst_match",  32'(match),  0);
    check("rst_wrap",   32'(wrap),   0);
    check("rst_status", 32'(status), 0);
    check("rst_irq",    32'(irq),    0);
    resetl   = 1'b1;
    m_count  = 0;
    m_status = '0;
    repeat (14) cycle();

    // Long line: two channels, period 799.
    clr = 1'b1; cycle(); clr = 1'b0;
    period = W'(799);
    set_cmp(0, 655);
    set_cmp(1, 751);
    cmp_en = 4'b0011;
    wraps  = 0;
    for (int k = 0; k < 1600; k++) begin
      cycle();
      if (wrap) wraps++;
    end
    check("wraps_per_1600", 32'(wraps), 2);

    // en toggling, period 3, channel 2 at 2.
    period = W'(3);
    set_cmp(2, 2);
    cmp_en = 4'b0100;
    clr = 1'b1; cycle(); clr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      en = k[0];
      cycle();
    end
    en = 1'b1;

    // clr at count 400 with a channel matching 400.
    period = W'(799);
    set_cmp(0, 400);
    cmp_en = 4'b0001;
    for (int k = 0; k < 2000 && m_count != 400; k++) cycle();
    check("reach_400", 32'(count), 400);
    clr = 1'b1; cycle(); clr = 1'b0;
    check("clr_no_match", 32'(match[0]), 0);

    // period 0: continuous wrap and match on channel 0; channel 1 at 9 idle.
    period = W'(0);
    set_cmp(0, 0);
    set_cmp(1, 9);
    cmp_en = 4'b0011;
    repeat (20) cycle();

    // Lowering period below count: roll over 2^W with no wrap pulse.
    period = W'(799);
    cmp_en = '0;
    for (int k = 0; k < 2000 && m_count != 500; k++) cycle();
    period = W'(100);
    repeat (1700) cycle();

    // Sticky status: set, set-with-ack, ack alone.
    period = W'(5);
    set_cmp(3, 2);
    cmp_en = 4'b1000;
    clr = 1'b1; cycle(); clr = 1'b0;
    repeat (3) cycle();
    check("sticky_set", 32'(status[3]), 32'(STICKY));
    repeat (5) cycle();
    ack = 4'b1000; cycle();
    check("sticky_set_wins", 32'(status[3]), 32'(STICKY));
    cycle();
    ack = '0; cycle();
    check("sticky_cleared", 32'(status[3]), 0);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      en  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 39) == 0);
      ack = N'($urandom);
      if ($urandom_range(0, 199) == 0) period = W'($urandom_range(0, 20));
      if ($urandom_range(0, 19) == 0) begin
        for (int i = 0; i < N; i++) set_cmp(i, $urandom_range(0, 24));
        cmp_en = N'($urandom);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vid_match_cnt.md
# vid_match_cnt

Parametrised video timing counter with multi-channel equality match detection, successor to the fixed 12-input AND terms used for counter decode in VID. A WIDTH-bit counter advances on a qualified tick, wraps at a programmable period, and compares against NCMP programmable values. Each compare is a wide AND of bit-equalities, with registered single-cycle match pulses. It replaces the hand-built nd6/nr2 decode trees for horizontal and vertical timing events.

## Interface
- WIDTH, 11, counter and compare width (2..16)
- NCMP, 4, number of compare channels (1..8)
- clk  in  1  system clock, all state on rising edge
- resetl  in  1  reset, asynchronous, active-low
- en  in  1  count tick qualifier
- clr  in  1  synchronous counter restart
- period  in  WIDTH  terminal count; counter sequence is 0..period
- cmp_val  in  NCMP*WIDTH  packed compare values, channel i at [i*WIDTH +: WIDTH]
- cmp_en  in  NCMP  per-channel compare enable
- ack  in  NCMP  per-channel sticky-status clear (VID_MATCH_STICKY_EN only)
- count  out  WIDTH  current counter value
- match  out  NCMP  registered one-cycle match pulses
- wrap  out  1  registered one-cycle terminal-count pulse
- status  out  NCMP  sticky match flags
- irq  out  1  OR of status

## Operation
- Reset (resetl low, asynchronous): count=0, match=0, wrap=0, status=0, irq=0.
- Priority per edge: clr > en > hold.
- clr=1: count<=0, match<=0, wrap<=0. Status is unaffected except by ack.
- clr=0, en=1:
  - count==period: count<=0, wrap<=1.
  - Otherwise: count<=count+1, wrap<=0.
  - Arithmetic is modulo 2^WIDTH. No overflow beyond period is possible unless period changes mid-frame.
- clr=0, en=0: count holds; match<=0, wrap<=0.
- match[i]<=1 iff clr=0, en=1, cmp_en[i]=1 and count==cmp_val[i]. Compare uses the pre-increment count (the value being counted out).
- Equality is an AND-reduction of WIDTH XNOR bits.
- cmp_val[i] > period: channel never fires.
- period changed to a value below the current count: the counter runs to 2^WIDTH-1, wraps naturally to 0 with wrap=0, then resumes the normal sequence.
- period=0: count stays 0; wrap pulses on every en cycle; a channel with cmp_val=0 pulses on every en cycle.
- Multiple channels may fire in the same cycle. Channels are independent.
- Changes to cmp_val, cmp_en and period take effect on the next compare (no shadowing).

## Timing
- match and wrap assert one clock after the en cycle in which the compared count is presented.
- Each pulse lasts exactly one cycle per qualifying en. Back-to-back en cycles with repeated equality (period=0) give continuous high.
- count updates one clock after en.
- Status and irq:
  - status[i] sets on the same edge as match[i].
  - irq follows status combinationally.
  - status[i] clears one clock after ack[i].
  - Simultaneous set and ack: set wins.

## Configuration
- VID_MATCH_STICKY_EN defined: status register and ack logic present; irq=|status.
- VID_MATCH_STICKY_EN undefined: status tied to 0, irq tied to 0, ack ignored. No sticky flops are instantiated. Counter and match behaviour are identical in both builds.

## Structure
- Shared package vid_pkg:
  - VID_CNT_W_DEFAULT=11
  - VID_NCMP_DEFAULT=4
  - function for channel slice offset
- Sub-module vid_and_tree: parametrised N-input AND, built as 6-input NAND groups and a NOR/NAND combine stage. Generalises the fixed 12-input decode. Used once per channel for equality and once for the terminal-count detect.

## Test plan
- Reset: hold resetl low with en=1, period=5 -> count=0, match=0, wrap=0, status=0. Release -> count runs 0,1,2,3,4,5,0; wrap pulses one cycle after count=5 is presented.
- WIDTH=11, period=799, cmp_val[0]=655, cmp_val[1]=751, cmp_en=2'b11, en=1 continuous -> match[0] high exactly one cycle following count=655, match[1] following count=751; one wrap per 800 cycles.
- en toggling every other cycle, period=3, cmp_val[2]=2 -> count advances only on en; match[2] pulses once per 4 ticks (8 clocks). match low on en=0 cycles.
- clr asserted with en=1 at count=400 -> count=0 next cycle, no match/wrap pulse from that cycle, even if cmp_val=400.
- period=0, cmp_val[0]=0, en=1 -> count stays 0, wrap and match[0] continuously high. cmp_val[1]=9 never fires.
- VID_MATCH_STICKY_EN build: match[3] fires -> status[3]=1, irq=1. ack[3] asserted on the same cycle as a new match -> status stays 1. ack alone -> status=0, irq=0 next cycle.
